// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data RAM with a fixed-latency load/store responder.
// A request is accepted in IDLE, runs LATENCY cycles through BUSY and completes
// in DONE with a one-cycle mem_ready pulse. Stores commit as DONE is left.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] hold_idx;
  logic [31:0]   hold_wdata;
  logic          hold_write;
  logic          hold_misal;

  // Word index and alignment of the incoming request; upper address bits wrap.
  logic [AW-1:0] req_idx;
  logic          req_misal;
  logic          commit;
  logic          unused_addr_bits;

  assign req_idx          = addr[AW+1:2];
  assign req_misal        = (addr[1:0] != 2'b00);
  assign unused_addr_bits = ^addr[31:AW+2];

  // NOTE: the RAM is deliberately left out of reset so it maps onto block RAM;
  // the declaration initialiser only gives simulation a defined zero start.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  // An aligned store writes the RAM on the edge that leaves DONE. Reset clears
  // hold_write asynchronously, so a store caught by reset is dropped.
  assign commit = (state == DONE) && hold_write && !hold_misal;

  // RAM write port.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[hold_idx] <= hold_wdata;
    end
  end

  // Transaction FSM with registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_idx   <= '0;
      hold_wdata <= '0;
      hold_write <= 1'b0;
      hold_misal <= 1'b0;
      rdata      <= '0;
      mem_ready  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          err       <= 1'b0;
          if (mem_read || mem_write) begin
            // Store wins when both request lines are high.
            hold_idx   <= req_idx;
            hold_wdata <= wdata;
            hold_write <= mem_write;
            hold_misal <= req_misal;
            cnt        <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              // Single-cycle latency completes straight from the request inputs.
              state     <= DONE;
              mem_ready <= 1'b1;
              err       <= req_misal;
              if (!mem_write) begin
                rdata <= req_misal ? 32'h0 : mem[req_idx];
              end
            end else begin
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            err       <= hold_misal;
            if (!hold_write) begin
              rdata <= hold_misal ? 32'h0 : mem[hold_idx];
            end
          end
        end

        DONE: begin
          // Requests seen here belong to the next instruction; take them in IDLE.
          state     <= IDLE;
          mem_ready <= 1'b0;
          err       <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: drives two responders (LATENCY=2 and LATENCY=1) with directed
// and random load/store traffic. Expected completions are queued at issue time
// from a plain array model of the RAM and popped by an independent monitor.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];
  logic        rd_v    [2];
  logic        wr_v    [2];
  logic        ready_v [2];
  logic        err_v   [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] ref_mem [2][1024];
  logic [31:0] ref_rd  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr_v[0]),
    .wdata    (wdata_v[0]),
    .mem_read (rd_v[0]),
    .mem_write(wr_v[0]),
    .rdata    (rdata_v[0]),
    .mem_ready(ready_v[0]),
    .err      (err_v[0])
  );

  dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr_v[1]),
    .wdata    (wdata_v[1]),
    .mem_read (rd_v[1]),
    .mem_write(wr_v[1]),
    .rdata    (rdata_v[1]),
    .mem_ready(ready_v[1]),
    .err      (err_v[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Issue one request on responder d (called at a negedge) and hold it until
  // mem_ready. b2b means the previous transaction is in its DONE cycle now.
  task automatic issue(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] wd, bit b2b);
    exp_t e;
    int   idx;
    int   n;
    bit   mis;
    idx = int'(a[11:2]);
    mis = (a[1:0] != 2'b00);
    if (wr) begin
      if (!mis) ref_mem[d][idx] = wd;
    end else begin
      ref_rd[d] = mis ? 32'h0 : ref_mem[d][idx];
    end
    e.rd  = ref_rd[d];
    e.err = mis;
    e.due = cyc + lat(d) + (b2b ? 1 : 0);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    addr_v[d]  = a;
    wdata_v[d] = wd;
    rd_v[d]    = rd;
    wr_v[d]    = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_v[d] && n < 40);
    if (!ready_v[d]) check($sformatf("d%0d_timeout", d), 32'(ready_v[d]), 32'h1);
  endtask

  task automatic idle(int d, int n);
    rd_v[d] = 1'b0;
    wr_v[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every mem_ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ready_v[d]) begin
          have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
          if (!have) begin
            check($sformatf("d%0d_spurious_ready", d), 32'h1, 32'h0);
          end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("d%0d_ready_cycle", d), cyc, e.due);
            check($sformatf("d%0d_err", d), 32'(err_v[d]), 32'(e.err));
            check($sformatf("d%0d_rdata", d), rdata_v[d], e.rd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) ref_mem[d][i] = 32'h0;
      ref_rd[d]  = 32'h0;
      addr_v[d]  = 32'h0;
      wdata_v[d] = 32'h0;
      rd_v[d]    = 1'b0;
      wr_v[d]    = 1'b0;
    end

    // Reset values while rst is held from time 0.
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_ready", d), 32'(ready_v[d]), 32'h0);
      check($sformatf("d%0d_rst_err", d), 32'(err_v[d]), 32'h0);
      check($sformatf("d%0d_rst_rdata", d), rdata_v[d], 32'h0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check($sformatf("d%0d_quiet", d), 32'(ready_v[d]), 32'h0);
    end

    // LATENCY=2: stores, read-after-write, back-to-back held loads.
    issue(0, 0, 1, 32'h14, 32'hCAFE_0005, 0);
    issue(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 1);
    issue(0, 1, 0, 32'h10, 32'h0, 1);
    issue(0, 1, 0, 32'h14, 32'h0, 1);
    idle(0, 1);
    // Misaligned store leaves the word intact; misaligned load returns zero.
    issue(0, 0, 1, 32'h20, 32'hA5A5_A5A5, 0);
    issue(0, 0, 1, 32'h22, 32'h0000_1234, 1);
    issue(0, 1, 0, 32'h20, 32'h0, 1);
    issue(0, 1, 0, 32'h23, 32'h0, 1);
    idle(0, 2);
    // Address wrap, then read+write together acts as a store.
    issue(0, 0, 1, 32'h1004, 32'h600D_F00D, 0);
    issue(0, 1, 0, 32'h0004, 32'h0, 1);
    issue(0, 1, 1, 32'h0008, 32'h0000_0077, 1);
    issue(0, 1, 0, 32'h0008, 32'h0, 1);
    issue(0, 0, 1, 32'h0040, 32'h1111_2222, 1);
    issue(0, 1, 0, 32'h0010, 32'h0, 1);
    idle(0, 1);

    // LATENCY=1.
    issue(1, 0, 1, 32'h30, 32'h3131_3131, 0);
    issue(1, 1, 0, 32'h30, 32'h0, 1);
    issue(1, 1, 1, 32'h34, 32'h0000_0055, 1);
    issue(1, 1, 0, 32'h34, 32'h0, 1);
    idle(1, 1);
    issue(1, 1, 0, 32'h30, 32'h0, 0);
    idle(1, 1);

    // Reset mid-cycle during BUSY of a store to 0x40: store must be dropped.
    addr_v[0]  = 32'h40;
    wdata_v[0] = 32'h0BAD_0BAD;
    wr_v[0]    = 1'b1;
    @(posedge clk);
    #2;
    rst     = 1'b1;
    wr_v[0] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_midrst_ready", d), 32'(ready_v[d]), 32'h0);
      check($sformatf("d%0d_midrst_err", d), 32'(err_v[d]), 32'h0);
      check($sformatf("d%0d_midrst_rdata", d), rdata_v[d], 32'h0);
      ref_rd[d] = 32'h0;
    end
    sb0.delete();
    sb1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check($sformatf("d%0d_postrst_quiet", d), 32'(ready_v[d]), 32'h0);
    end
    issue(0, 1, 0, 32'h40, 32'h0, 0);
    idle(0, 1);

    // Random bursts on both responders.
    for (int b = 0; b < 120; b++) begin
      int d;
      int len;
      d   = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        logic [31:0] a;
        int          op;
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        op = int'($urandom_range(0, 3));
        issue(d, (op != 2), (op >= 2), a, $urandom, (k != 0));
      end
      idle(d, int'($urandom_range(1, 3)));
    end

    repeat (5) @(negedge clk);
    check("sb0_drained", 32'(sb0.size()), 32'h0);
    check("sb1_drained", 32'(sb1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
